// File: rtl/snn_ctrl_fsm_if.sv
// rtl/snn_ctrl_fsm_if.sv - CPU command strobes and engine req/done handshakes of the SNN controller
interface snn_ctrl_fsm_if #(
   parameter int DATA_WIDTH = 16
);
   logic [1:0]            enc_sel_i;
   logic                  pre_start_i;
   logic                  enc_start_i;
   logic                  snn_start_i;
   logic                  clear_i;
   logic                  wait_snn_i;
   logic                  output_snn_i;
   logic                  pre_req_o;
   logic                  pre_done_i;
   logic                  enc_req_o;
   logic [1:0]            enc_sel_o;
   logic                  enc_done_i;
   logic                  snn_req_o;
   logic                  snn_done_i;
   logic [DATA_WIDTH-1:0] snn_result_i;
   logic                  clear_o;
   logic                  hold_o;
   logic                  busy_o;
   logic [DATA_WIDTH-1:0] result_o;
   logic                  result_valid_o;
   logic                  err_o;
   logic [31:0]           cycle_cnt_o;

   modport master (
      output enc_sel_i, pre_start_i, enc_start_i, snn_start_i, clear_i, wait_snn_i,
             output_snn_i, pre_done_i, enc_done_i, snn_done_i, snn_result_i,
      input  pre_req_o, enc_req_o, enc_sel_o, snn_req_o, clear_o, hold_o, busy_o,
             result_o, result_valid_o, err_o, cycle_cnt_o
   );

   modport slave (
      input  enc_sel_i, pre_start_i, enc_start_i, snn_start_i, clear_i, wait_snn_i,
             output_snn_i, pre_done_i, enc_done_i, snn_done_i, snn_result_i,
      output pre_req_o, enc_req_o, enc_sel_o, snn_req_o, clear_o, hold_o, busy_o,
             result_o, result_valid_o, err_o, cycle_cnt_o
   );
endinterface

// File: rtl/snn_ctrl_fsm.sv
// rtl/snn_ctrl_fsm.sv - SNN command sequencer (pre/enc/snn phases, timeout, CPU stall)
// Optional SNN-phase cycle counter built when SNN_CTRL_CYCLE_CNT_EN is defined.
module snn_ctrl_fsm #(
   parameter int DATA_WIDTH     = 16,
   parameter int TIMEOUT_CYCLES = 4096,
   parameter int TIMEOUT_W      = 16
) (
   input  logic          clk,
   input  logic          rst_n,
   snn_ctrl_fsm_if.slave bus
);
   localparam logic [2:0] ST_IDLE = 3'd0;
   localparam logic [2:0] ST_PRE  = 3'd1;
   localparam logic [2:0] ST_ENC  = 3'd2;
   localparam logic [2:0] ST_SNN  = 3'd3;
   localparam logic [2:0] ST_DONE = 3'd4;

   localparam logic [TIMEOUT_W-1:0] TO_LAST =
      TIMEOUT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

   logic [2:0]            state;
   logic [1:0]            enc_sel_q;
   logic [DATA_WIDTH-1:0] result_q;
   logic                  result_valid_q;
   logic                  err_q;
   logic                  clear_q;
   logic [TIMEOUT_W-1:0]  phase_cnt;

   logic any_start, multi_start, in_phase, can_start, phase_done, timeout;

   assign any_start   = bus.pre_start_i | bus.enc_start_i | bus.snn_start_i;
   assign multi_start = (bus.pre_start_i & (bus.enc_start_i | bus.snn_start_i)) |
                        (bus.enc_start_i & bus.snn_start_i);
   assign in_phase    = (state == ST_PRE) || (state == ST_ENC) || (state == ST_SNN);
   assign can_start   = (state == ST_IDLE) || (state == ST_DONE);
   // The counter sits at TO_LAST during the final allowed cycle of the phase.
   assign timeout     = (TIMEOUT_CYCLES != 0) && in_phase && (phase_cnt == TO_LAST);

   always_comb begin
      phase_done = 1'b0;
      case (state)
         ST_PRE:  phase_done = bus.pre_done_i;
         ST_ENC:  phase_done = bus.enc_done_i;
         ST_SNN:  phase_done = bus.snn_done_i;
         default: phase_done = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state          <= ST_IDLE;
         enc_sel_q      <= '0;
         result_q       <= '0;
         result_valid_q <= 1'b0;
         err_q          <= 1'b0;
         clear_q        <= 1'b0;
         phase_cnt      <= '0;
      end else begin
         clear_q <= 1'b0;
         if (bus.clear_i) begin
            // A start strobe that loses to clear is still reported.
            state          <= ST_IDLE;
            result_q       <= '0;
            result_valid_q <= 1'b0;
            err_q          <= any_start;
            clear_q        <= 1'b1;
            phase_cnt      <= '0;
         end else begin
            if (multi_start)
               err_q <= 1'b1;
            if (can_start && any_start) begin
               result_valid_q <= 1'b0;
               phase_cnt      <= '0;
               if (bus.pre_start_i) begin
                  state <= ST_PRE;
               end else if (bus.enc_start_i) begin
                  state     <= ST_ENC;
                  enc_sel_q <= bus.enc_sel_i;
               end else begin
                  state <= ST_SNN;
               end
            end else begin
               if (any_start)
                  err_q <= 1'b1;
               if (in_phase)
                  phase_cnt <= phase_cnt + 1'b1;
               if (in_phase && phase_done) begin
                  if (state == ST_SNN) begin
                     result_q       <= bus.snn_result_i;
                     result_valid_q <= 1'b1;
                     state          <= ST_DONE;
                  end else begin
                     state <= ST_IDLE;
                  end
               end else if (timeout) begin
                  state   <= ST_IDLE;
                  err_q   <= 1'b1;
                  clear_q <= 1'b1;
               end
               if (bus.output_snn_i) begin
                  if (state == ST_DONE) begin
                     result_valid_q <= 1'b0;
                     state          <= ST_IDLE;
                  end else begin
                     err_q <= 1'b1;
                  end
               end
            end
         end
      end
   end

`ifdef SNN_CTRL_CYCLE_CNT_EN
   logic [31:0] cyc_q;

   always_ff @(posedge clk) begin
      if (!rst_n || bus.clear_i) begin
         cyc_q <= '0;
      end else if (can_start && bus.snn_start_i && !bus.pre_start_i && !bus.enc_start_i) begin
         cyc_q <= '0;
      end else if ((state == ST_SNN) && (cyc_q != 32'hFFFF_FFFF)) begin
         cyc_q <= cyc_q + 32'd1;
      end
   end

   assign bus.cycle_cnt_o = cyc_q;
`else
   assign bus.cycle_cnt_o = '0;
`endif

   assign bus.pre_req_o      = (state == ST_PRE);
   assign bus.enc_req_o      = (state == ST_ENC);
   assign bus.snn_req_o      = (state == ST_SNN);
   assign bus.busy_o         = in_phase;
   assign bus.hold_o         = bus.wait_snn_i && (state == ST_SNN);
   assign bus.enc_sel_o      = enc_sel_q;
   assign bus.result_o       = result_q;
   assign bus.result_valid_o = result_valid_q;
   assign bus.err_o          = err_q;
   assign bus.clear_o        = clear_q;
endmodule

// File: tb/tb_snn_ctrl_fsm.sv
// tb/tb_snn_ctrl_fsm.sv - directed bench for snn_ctrl_fsm (default and short-timeout instances)
module tb_snn_ctrl_fsm;
   logic clk;
   logic rst_n;
   int   n_assert;
   int   n_fail;

`ifdef SNN_CTRL_CYCLE_CNT_EN
   localparam bit CNT_EN = 1'b1;
`else
   localparam bit CNT_EN = 1'b0;
`endif

   snn_ctrl_fsm_if #(.DATA_WIDTH(16)) if_a ();
   snn_ctrl_fsm_if #(.DATA_WIDTH(16)) if_b ();

   snn_ctrl_fsm #(.DATA_WIDTH(16), .TIMEOUT_CYCLES(4096), .TIMEOUT_W(16)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (if_a)
   );

   snn_ctrl_fsm #(.DATA_WIDTH(16), .TIMEOUT_CYCLES(8), .TIMEOUT_W(16)) u_dut_to (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (if_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   initial begin
      n_assert = 0;
      n_fail   = 0;
      rst_n    = 1'b0;
      {if_a.enc_sel_i, if_a.pre_start_i, if_a.enc_start_i, if_a.snn_start_i, if_a.clear_i,
       if_a.wait_snn_i, if_a.output_snn_i, if_a.pre_done_i, if_a.enc_done_i, if_a.snn_done_i} = '0;
      if_a.snn_result_i = '0;
      {if_b.enc_sel_i, if_b.pre_start_i, if_b.enc_start_i, if_b.snn_start_i, if_b.clear_i,
       if_b.wait_snn_i, if_b.output_snn_i, if_b.pre_done_i, if_b.enc_done_i, if_b.snn_done_i} = '0;
      if_b.snn_result_i = '0;

      tick();
      tick();
      chk("rst_busy", if_a.busy_o, 0);
      chk("rst_reqs", {if_a.pre_req_o, if_a.enc_req_o, if_a.snn_req_o}, 0);
      chk("rst_enc_sel", if_a.enc_sel_o, 0);
      chk("rst_result", if_a.result_o, 0);
      chk("rst_flags", {if_a.result_valid_o, if_a.err_o, if_a.clear_o, if_a.hold_o}, 0);
      chk("rst_cyc", if_a.cycle_cnt_o, 0);
      rst_n = 1'b1;
      tick();

      // pre phase
      if_a.pre_start_i = 1'b1;
      tick();
      if_a.pre_start_i = 1'b0;
      chk("pre_req_on", if_a.pre_req_o, 1);
      chk("pre_busy", if_a.busy_o, 1);
      for (int i = 0; i < 4; i++) tick();
      chk("pre_req_hold", if_a.pre_req_o, 1);
      if_a.pre_done_i = 1'b1;
      tick();
      if_a.pre_done_i = 1'b0;
      chk("pre_req_off", if_a.pre_req_o, 0);
      chk("pre_busy_off", if_a.busy_o, 0);
      chk("pre_err", if_a.err_o, 0);

      // enc phase with a stray start
      if_a.enc_sel_i   = 2'b10;
      if_a.enc_start_i = 1'b1;
      tick();
      if_a.enc_start_i = 1'b0;
      if_a.enc_sel_i   = 2'b00;
      chk("enc_sel", if_a.enc_sel_o, 2'b10);
      chk("enc_req", if_a.enc_req_o, 1);
      if_a.pre_start_i = 1'b1;
      tick();
      if_a.pre_start_i = 1'b0;
      chk("enc_stray_err", if_a.err_o, 1);
      chk("enc_stay", {if_a.pre_req_o, if_a.enc_req_o}, 2'b01);
      if_a.snn_done_i = 1'b1;
      tick();
      if_a.snn_done_i = 1'b0;
      chk("enc_foreign_done", if_a.enc_req_o, 1);
      if_a.enc_done_i = 1'b1;
      tick();
      if_a.enc_done_i = 1'b0;
      chk("enc_done", {if_a.enc_req_o, if_a.busy_o}, 0);
      chk("enc_sel_kept", if_a.enc_sel_o, 2'b10);
      chk("err_sticky", if_a.err_o, 1);
      if_a.clear_i = 1'b1;
      tick();
      if_a.clear_i = 1'b0;
      chk("clr_pulse", if_a.clear_o, 1);
      chk("clr_err", if_a.err_o, 0);
      tick();
      chk("clr_pulse_end", if_a.clear_o, 0);

      // snn phase, 20 cycles with hold
      if_a.snn_start_i = 1'b1;
      if_a.wait_snn_i  = 1'b1;
      tick();
      if_a.snn_start_i = 1'b0;
      chk("snn_req", if_a.snn_req_o, 1);
      chk("hold_first", if_a.hold_o, 1);
      for (int i = 0; i < 19; i++) begin
         tick();
         chk("hold_mid", if_a.hold_o, 1);
      end
      if_a.snn_done_i   = 1'b1;
      if_a.snn_result_i = 16'h00A5;
      tick();
      if_a.snn_done_i   = 1'b0;
      if_a.snn_result_i = 16'h0000;
      chk("hold_drop", if_a.hold_o, 0);
      chk("snn_result", if_a.result_o, 16'h00A5);
      chk("snn_valid", if_a.result_valid_o, 1);
      chk("snn_reqs_off", {if_a.snn_req_o, if_a.busy_o}, 0);
      chk("snn_cyc20", if_a.cycle_cnt_o, CNT_EN ? 32'd20 : 32'd0);
      if_a.wait_snn_i   = 1'b0;
      if_a.output_snn_i = 1'b1;
      tick();
      if_a.output_snn_i = 1'b0;
      chk("out_valid", if_a.result_valid_o, 0);
      chk("out_result", if_a.result_o, 16'h00A5);
      chk("out_err", if_a.err_o, 0);
      if_a.output_snn_i = 1'b1;
      tick();
      if_a.output_snn_i = 1'b0;
      chk("out_idle_err", if_a.err_o, 1);
      if_a.clear_i = 1'b1;
      tick();
      if_a.clear_i = 1'b0;
      chk("clr_result", if_a.result_o, 0);

      // 37-cycle snn phase for the cycle counter
      if_a.snn_start_i = 1'b1;
      tick();
      if_a.snn_start_i = 1'b0;
      for (int i = 0; i < 36; i++) tick();
      if_a.snn_done_i   = 1'b1;
      if_a.snn_result_i = 16'h1357;
      tick();
      if_a.snn_done_i   = 1'b0;
      chk("cyc37", if_a.cycle_cnt_o, CNT_EN ? 32'd37 : 32'd0);
      for (int i = 0; i < 3; i++) tick();
      chk("cyc37_hold", if_a.cycle_cnt_o, CNT_EN ? 32'd37 : 32'd0);
      chk("res37", if_a.result_o, 16'h1357);

      // start from DONE discards the result
      if_a.snn_start_i = 1'b1;
      tick();
      if_a.snn_start_i = 1'b0;
      chk("done_restart_valid", if_a.result_valid_o, 0);
      chk("done_restart_req", if_a.snn_req_o, 1);
      for (int i = 0; i < 3; i++) tick();
      if_a.clear_i = 1'b1;
      tick();
      if_a.clear_i = 1'b0;
      chk("clr_snn_req", if_a.snn_req_o, 0);
      chk("clr_snn_pulse", if_a.clear_o, 1);
      chk("clr_snn_flags", {if_a.err_o, if_a.result_valid_o}, 0);
      chk("clr_snn_cyc", if_a.cycle_cnt_o, 0);
      tick();
      chk("clr_snn_pulse_end", if_a.clear_o, 0);

      // clear beats a simultaneous start
      if_a.snn_start_i = 1'b1;
      tick();
      if_a.snn_start_i = 1'b0;
      tick();
      if_a.clear_i     = 1'b1;
      if_a.pre_start_i = 1'b1;
      tick();
      if_a.clear_i     = 1'b0;
      if_a.pre_start_i = 1'b0;
      chk("clr_pri_state", {if_a.pre_req_o, if_a.snn_req_o, if_a.busy_o}, 0);
      chk("clr_pri_err", if_a.err_o, 1);
      chk("clr_pri_pulse", if_a.clear_o, 1);
      if_a.clear_i = 1'b1;
      tick();
      if_a.clear_i = 1'b0;

      // pre beats snn when both start together
      if_a.pre_start_i = 1'b1;
      if_a.snn_start_i = 1'b1;
      tick();
      if_a.pre_start_i = 1'b0;
      if_a.snn_start_i = 1'b0;
      chk("multi_pick", {if_a.pre_req_o, if_a.snn_req_o}, 2'b10);
      chk("multi_err", if_a.err_o, 1);
      if_a.pre_done_i = 1'b1;
      tick();
      if_a.pre_done_i = 1'b0;

      // timeout on the 8-cycle instance
      if_b.snn_start_i = 1'b1;
      tick();
      if_b.snn_start_i = 1'b0;
      chk("to_req", if_b.snn_req_o, 1);
      for (int i = 0; i < 7; i++) begin
         tick();
         chk("to_still_busy", if_b.busy_o, 1);
      end
      tick();
      chk("to_idle", {if_b.snn_req_o, if_b.busy_o}, 0);
      chk("to_err", if_b.err_o, 1);
      chk("to_pulse", if_b.clear_o, 1);
      tick();
      chk("to_pulse_end", if_b.clear_o, 0);
      if_b.clear_i = 1'b1;
      tick();
      if_b.clear_i = 1'b0;

      // done in the last cycle beats the timeout
      if_b.snn_start_i = 1'b1;
      tick();
      if_b.snn_start_i = 1'b0;
      for (int i = 0; i < 7; i++) tick();
      if_b.snn_done_i   = 1'b1;
      if_b.snn_result_i = 16'h1234;
      tick();
      if_b.snn_done_i   = 1'b0;
      chk("to_done_wins_res", if_b.result_o, 16'h1234);
      chk("to_done_wins_flags", {if_b.result_valid_o, if_b.err_o, if_b.clear_o}, 3'b100);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule

// File: doc/snn_ctrl_fsm.md
Name: snn_ctrl_fsm

Overview:
- Responder end of the CPU's SNN command strobes (enc_sel, pre_start, enc_start, snn_start, clear, wait_snn, output_snn) driven from the EX stage.
- Sequences the pre-processing, spike-encoder and SNN-core engines through req/done handshakes.
- Captures the SNN result and stalls the CPU through hold_o while it waits on the network.
- Sits beside the pipeline, between EX and the SNN datapath.

Parameters:
- DATA_WIDTH, 16, width of the SNN result.
- TIMEOUT_CYCLES, 4096, maximum cycles any phase waits for done; 0 disables the timeout.
- TIMEOUT_W, 16, width of the phase cycle counter; must hold TIMEOUT_CYCLES.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous reset, active-low.
- enc_sel_i  in  2  encoder select; latched on enc_start_i.
- pre_start_i  in  1  one-cycle command: start pre-processing.
- enc_start_i  in  1  one-cycle command: start encoding.
- snn_start_i  in  1  one-cycle command: start SNN inference.
- clear_i  in  1  one-cycle command: abort and clear.
- wait_snn_i  in  1  level; CPU is blocked on the SNN.
- output_snn_i  in  1  one-cycle command: CPU consumes the result.
- pre_req_o  out  1  pre-processing request (level).
- pre_done_i  in  1  pre-processing done.
- enc_req_o  out  1  encoder request (level).
- enc_sel_o  out  2  latched encoder select.
- enc_done_i  in  1  encoder done.
- snn_req_o  out  1  SNN request (level).
- snn_done_i  in  1  SNN done.
- snn_result_i  in  DATA_WIDTH  SNN result; valid with snn_done_i.
- clear_o  out  1  one-cycle clear pulse to the engines.
- hold_o  out  1  stall to the CPU pipeline.
- busy_o  out  1  a phase is in progress.
- result_o  out  DATA_WIDTH  captured result.
- result_valid_o  out  1  result not yet consumed.
- err_o  out  1  sticky error.
- cycle_cnt_o  out  32  SNN-phase cycle count (see Optional Feature).

Behaviour:
- Reset (rst_n=0 at a clk edge): state IDLE. All outputs 0, including enc_sel_o, result_o and the counters.
- States: IDLE, PRE, ENC, SNN, DONE. Registered one-hot or binary encoding.
- Command priority when several strobes are high in one cycle: clear > pre > enc > snn. Only the highest is taken; err_o is set if any other start strobe was also high.
- Starts are accepted only in IDLE or DONE.
  - pre_start_i → PRE.
  - enc_start_i → ENC; enc_sel_o <= enc_sel_i.
  - snn_start_i → SNN.
  - Taking a start from DONE discards result_valid_o.
  - A start received in PRE, ENC or SNN is ignored and sets err_o.
- Latency: a start at edge n gives the new state and its req_o=1 after edge n. busy_o=1 in PRE, ENC and SNN.
- Phase handshake: req_o holds 1 for the whole phase.
  - done_i is sampled only in the matching state. done_i for any other phase is ignored and is not an error.
  - PRE or ENC with done=1 → IDLE; req_o drops the following cycle.
  - SNN with snn_done_i=1: result_o <= snn_result_i, result_valid_o <= 1, state → DONE.
- Timeout: the phase counter clears on phase entry and increments every cycle while in the phase. If it reaches TIMEOUT_CYCLES before done (and TIMEOUT_CYCLES != 0): state → IDLE, err_o <= 1, clear_o pulses. When done and timeout occur in the same cycle, done wins.
- hold_o = wait_snn_i & (state==SNN). It is combinational, drops in the cycle after snn_done_i, and is 0 otherwise.
- output_snn_i:
  - In DONE: result_valid_o <= 0, state → IDLE, result_o retained.
  - In any other state: ignored, and err_o is set.
- clear_i in any state: state → IDLE; req_o all 0; result_valid_o, err_o and result_o all cleared; clear_o=1 for exactly one cycle after the edge.
- Reset mid-phase is identical to reset: reqs drop immediately and no clear_o pulse is emitted.
- err_o is sticky and is cleared only by clear_i or reset.

Optional Feature:
- Macro SNN_CTRL_CYCLE_CNT_EN.
- Defined: a 32-bit counter clears on SNN entry, increments every cycle in SNN, and freezes on exit. cycle_cnt_o drives the count; clear_i and reset zero it. The counter saturates at 0xFFFFFFFF.
- Undefined: cycle_cnt_o is tied to 0 and no counter logic is built.

Test Plan:
- Reset, then pre_start_i pulse → pre_req_o=1 the next cycle. pre_done_i after 5 cycles → pre_req_o=0 and busy_o=0 the next cycle; err_o=0.
- enc_sel_i=2'b10 with enc_start_i → enc_sel_o=2'b10 and enc_req_o=1. A pre_start_i during ENC → err_o=1 and the state stays ENC.
- snn_start_i, wait_snn_i=1, snn_done_i with snn_result_i=16'h00A5 after 20 cycles → hold_o=1 for those 20 cycles; then result_o=16'h00A5 and result_valid_o=1. output_snn_i → result_valid_o=0 and result_o stays 16'h00A5.
- TIMEOUT_CYCLES=8, snn_start_i with no done → after 8 cycles state is IDLE, err_o=1, clear_o pulses once.
- clear_i mid-SNN → snn_req_o=0, clear_o=1 for one cycle, err_o=0, result_valid_o=0. The same cycle with pre_start_i also high → clear wins and err_o=1.
- With SNN_CTRL_CYCLE_CNT_EN defined and a 37-cycle SNN phase → cycle_cnt_o=37, holding after exit. Without the macro → cycle_cnt_o=0.
